// File: rtl/coef_rom.sv
// coef_rom: registered lookup of the 17 symmetric FIR taps.
// The table is defined at 18 bits and adapted to Wc at elaboration.
module coef_rom #(
  parameter int Num_coef = 17,
  parameter int Wc       = 18
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(Num_coef)-1:0]     addr,
  output logic signed [Wc-1:0]            data
);

  localparam int AW    = $clog2(Num_coef);
  localparam int DEPTH = 2 ** AW;
  localparam int WB    = 18;
  localparam int NBASE = 17;
  localparam int WM    = (Wc > WB) ? Wc : WB;

  typedef logic [DEPTH-1:0][Wc-1:0] rom_t;

  function automatic logic signed [WB-1:0] base_coef(input int i);
    logic signed [WB-1:0] v;
    int k;
    k = (i > 8) ? (16 - i) : i;
    unique case (k)
      0:       v = -18'sd328;
      1:       v = -18'sd786;
      2:       v = -18'sd1049;
      3:       v = 18'sd0;
      4:       v = 18'sd3146;
      5:       v = 18'sd7864;
      6:       v = 18'sd12583;
      7:       v = 18'sd15729;
      8:       v = 18'sd16384;
      default: v = 18'sd0;
    endcase
    return v;
  endfunction

  // Widen by sign extension, narrow by arithmetic shift keeping MSBs.
  function automatic logic [Wc-1:0] adapt(input logic signed [WB-1:0] b);
    logic signed [WM-1:0] t;
    t = WM'(b);
    t = t >>> (WM - Wc);
    return t[Wc-1:0];
  endfunction

  function automatic rom_t build_rom();
    rom_t r;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < Num_coef && i < NBASE)
        r[i] = adapt(base_coef(i));
      else
        r[i] = '0;
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  logic [Wc-1:0] w_rd;
  assign w_rd = ROM[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data <= '0;
    else
      data <= w_rd;
  end

endmodule

// File: tb/tb_coef_rom.sv
// tb_coef_rom: random and directed reads against a table model.
// Covers reset, sweep, wrap, out-of-range and async mid-stream reset.
module tb_coef_rom;

  logic               clk;
  logic               rst;
  logic [4:0]         addr;
  logic signed [17:0] data;

  int n_cmp = 0;
  int n_bad = 0;

  int tbl [17] = '{-328, -786, -1049, 0, 3146, 7864, 12583, 15729,
                   16384, 15729, 12583, 7864, 3146, 0, -1049, -786, -328};

  coef_rom #(.Num_coef(17), .Wc(18)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [17:0] model(input int a);
    if (a >= 0 && a < 17)
      return 18'(tbl[a]);
    return 18'sd0;
  endfunction

  task automatic check(input string tag,
                       input logic signed [17:0] got,
                       input logic signed [17:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic rd(input int a, input string tag);
    addr = 5'(a);
    @(posedge clk);
    #1;
    check(tag, data, model(a));
  endtask

  initial begin
    int a;
    rst  = 1'b1;
    addr = 'x;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("reset_hold", data, 18'sd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release", data, 18'sd0);

    for (int i = 0; i < 17; i++) rd(i, "sweep");

    for (int c = 0; c < 500; c++) rd(c % 17, "wrap");

    rd(17, "oor17");
    rd(24, "oor24");
    rd(31, "oor31");
    rd(8, "after_oor");

    for (int i = 0; i < 8; i++) rd(i, "pre_rst");
    addr = 5'd8;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", data, 18'sd0);
    #1;
    rst  = 1'b0;
    addr = 5'd5;
    #1;
    check("rst_low_hold", data, 18'sd0);
    @(posedge clk);
    #1;
    check("resume", data, 18'sd7864);

    for (int c = 0; c < 300; c++) begin
      a = int'($urandom_range(0, 16));
      rd(a, "rand_in");
    end
    for (int c = 0; c < 200; c++) begin
      a = int'($urandom_range(0, 31));
      rd(a, "rand_any");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
